// File: rtl/ntt_mem_responder.sv
// Round-robin memory responder for the NTT core request/grant/valid bus.
// One access per cycle into a 64-bit word SRAM, fixed-latency read return, host preload port.
module ntt_mem_responder #(
  parameter int unsigned NumCores = 4,
  parameter int unsigned Depth    = 4096,
  parameter int unsigned RdLat    = 2,
  parameter logic [63:0] OobData  = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCores-1:0]    core_req_i,
  input  logic [NumCores-1:0]    core_we_i,
  input  logic [NumCores*64-1:0] core_addr_i,
  input  logic [NumCores*64-1:0] core_wdata_i,
  output logic [NumCores-1:0]    core_gnt_o,
  output logic [NumCores-1:0]    core_valid_o,
  output logic [63:0]            core_rdata_o,
  input  logic                   host_we_i,
  input  logic [63:0]            host_addr_i,
  input  logic [63:0]            host_wdata_i,
  output logic [63:0]            grant_count_o,
  output logic [31:0]            oob_count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned IdW   = (NumCores > 1) ? $clog2(NumCores) : 1;

  logic [NumCores-1:0] gnt_q, gnt_d;
  logic [NumCores-1:0] valid_q, valid_d;
  logic [63:0]         rdata_q, rdata_d;
  logic [63:0]         grant_cnt_q, grant_cnt_d;
  logic [31:0]         oob_cnt_q, oob_cnt_d;
  logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [NumCores-1:0] eligible;
  logic                win_found;
  logic [IdW-1:0]      win_id;
  logic                core_fire;
  logic                sel_we;
  logic [63:0]         sel_addr;
  logic [63:0]         sel_wdata;
  logic                sel_legal;
  logic [AddrW-1:0]    sel_idx;
  logic                host_legal;
  logic [AddrW-1:0]    host_idx;

  logic                pipe_vld_q  [RdLat];
  logic [IdW-1:0]      pipe_id_q   [RdLat];
  logic [63:0]         pipe_data_q [RdLat];

  logic [63:0]         mem_q [Depth];

  // Word-aligned and inside the array; upper address bits must be zero.
  function automatic logic addr_legal(input logic [63:0] addr);
    logic [63:0] hi;
    hi = addr >> (AddrW + 3);
    return (addr[2:0] == 3'b000) && (hi == 64'd0);
  endfunction

  // A core granted this cycle is masked so it cannot win two edges in a row.
  assign eligible = core_req_i & ~gnt_q;

  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < NumCores; k++) begin
      cand = (32'(rr_ptr_q) + k) % NumCores;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = IdW'(cand);
      end
    end
  end

  assign core_fire = win_found && !host_we_i && !rst_i;

  always_comb begin
    sel_we    = core_we_i[win_id];
    sel_addr  = core_addr_i[64*int'(win_id) +: 64];
    sel_wdata = core_wdata_i[64*int'(win_id) +: 64];
  end

  assign sel_legal  = addr_legal(sel_addr);
  assign sel_idx    = sel_addr[3 +: AddrW];
  assign host_legal = addr_legal(host_addr_i);
  assign host_idx   = host_addr_i[3 +: AddrW];

  always_comb begin
    gnt_d       = '0;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;
    oob_cnt_d   = oob_cnt_q;
    if (core_fire) begin
      gnt_d[win_id] = 1'b1;
      rr_ptr_d      = IdW'((32'(win_id) + 1) % NumCores);
      grant_cnt_d   = grant_cnt_q + 64'd1;
      if (!sel_legal && (oob_cnt_q != 32'hFFFF_FFFF)) begin
        oob_cnt_d = oob_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    valid_d = '0;
    rdata_d = rdata_q;
    if (pipe_vld_q[RdLat-1]) begin
      valid_d[pipe_id_q[RdLat-1]] = 1'b1;
      rdata_d                     = pipe_data_q[RdLat-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q       <= '0;
      valid_q     <= '0;
      rdata_q     <= '0;
      grant_cnt_q <= '0;
      oob_cnt_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      gnt_q       <= gnt_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
      grant_cnt_q <= grant_cnt_d;
      oob_cnt_q   <= oob_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Only the valid bits need a reset; flushing them drops in-flight reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < RdLat; k++) begin
        pipe_vld_q[k] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0] <= core_fire && !sel_we;
      for (int unsigned k = 1; k < RdLat; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (core_fire && !sel_we) begin
      pipe_id_q[0]   <= win_id;
      pipe_data_q[0] <= sel_legal ? mem_q[sel_idx] : OobData;
    end
    for (int unsigned k = 1; k < RdLat; k++) begin
      pipe_id_q[k]   <= pipe_id_q[k-1];
      pipe_data_q[k] <= pipe_data_q[k-1];
    end
  end

  // Host and core writes never collide: a host write blocks every core grant.
  always_ff @(posedge clk_i) begin
    if (host_we_i && host_legal) begin
      mem_q[host_idx] <= host_wdata_i;
    end else if (core_fire && sel_we && sel_legal) begin
      mem_q[sel_idx] <= sel_wdata;
    end
  end

  assign core_gnt_o    = gnt_q;
  assign core_valid_o  = valid_q;
  assign core_rdata_o  = rdata_q;
  assign grant_count_o = grant_cnt_q;
  assign oob_count_o   = oob_cnt_q;

endmodule

// File: tb/tb_ntt_mem_responder.sv
// Bench for ntt_mem_responder: per-core request queues, a read-return scoreboard,
// a table of single-read vectors and directed sequences for the multi-cycle cases.
module tb_ntt_mem_responder;

  localparam int unsigned NumCores = 4;
  localparam int unsigned Depth    = 4096;
  localparam int unsigned RdLat    = 2;
  localparam logic [63:0] Oob      = 64'hDEAD_DEAD_DEAD_DEAD;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NumCores-1:0]    core_req, core_we, core_gnt, core_valid;
  logic [NumCores*64-1:0] core_addr, core_wdata;
  logic [63:0]            core_rdata, host_addr, host_wdata, grant_count;
  logic                   host_we;
  logic [31:0]            oob_count;

  always #5 clk = ~clk;

  ntt_mem_responder #(
    .NumCores(NumCores),
    .Depth   (Depth),
    .RdLat   (RdLat),
    .OobData (Oob)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_gnt_o   (core_gnt),
    .core_valid_o (core_valid),
    .core_rdata_o (core_rdata),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .grant_count_o(grant_count),
    .oob_count_o  (oob_count)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } op_t;
  typedef struct {
    int          id;
    logic [63:0] data;
    int          due;
  } sb_t;
  typedef struct {
    int id;
    int cyc;
  } gl_t;
  typedef struct {
    logic [63:0] addr;
    logic        pre;
    logic [63:0] data;
    logic [63:0] exp;
    int          oob_inc;
  } vec_t;

  op_t  drv_q [NumCores][$];
  sb_t  sb_q[$];
  gl_t  gl_q[$];
  vec_t vecs[7];
  int   cyc, checks, errors, exp_grants, exp_oob;

  function automatic logic legal(input logic [63:0] a);
    return (a[2:0] == 3'b000) && (a < 64'(Depth) * 64'd8);
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_core(input int i);
    if (drv_q[i].size() > 0) begin
      core_req[i]            = 1'b1;
      core_we[i]             = drv_q[i][0].we;
      core_addr[64*i +: 64]  = drv_q[i][0].addr;
      core_wdata[64*i +: 64] = drv_q[i][0].wdata;
    end else begin
      core_req[i] = 1'b0;
    end
  endtask

  task automatic enq(input int i, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [63:0] exp);
    op_t op;
    op = '{we: we, addr: addr, wdata: wdata, exp: exp};
    drv_q[i].push_back(op);
    exp_grants++;
    if (!legal(addr)) exp_oob++;
    drive_core(i);
  endtask

  task automatic monitor();
    op_t                 op;
    sb_t                 s;
    logic [NumCores-1:0] oh;
    checks++;
    if (!$onehot0(core_gnt)) begin
      errors++;
      $display("FAIL gnt_onehot: got %b expected one-hot or zero", core_gnt);
    end
    for (int i = 0; i < NumCores; i++) begin
      if (core_gnt[i]) begin
        if (drv_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gnt: got gnt[%0d] at cycle %0d expected none", i, cyc);
        end else begin
          op = drv_q[i].pop_front();
          gl_q.push_back('{id: i, cyc: cyc});
          if (!op.we) sb_q.push_back('{id: i, data: op.exp, due: cyc + int'(RdLat)});
          drive_core(i);
        end
      end
    end
    if (core_valid != '0) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got valid=%b at cycle %0d expected none",
                 core_valid, cyc);
      end else begin
        s      = sb_q.pop_front();
        oh     = '0;
        oh[s.id] = 1'b1;
        if (core_valid !== oh || cyc != s.due || core_rdata !== s.data) begin
          errors++;
          $display("FAIL read_return: got valid=%b cyc=%0d rdata=%h expected valid=%b cyc=%0d rdata=%h",
                   core_valid, cyc, core_rdata, oh, s.due, s.data);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_valid: got none at cycle %0d expected core %0d", cyc, sb_q[0].id);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  function automatic bit busy();
    for (int i = 0; i < NumCores; i++) if (drv_q[i].size() != 0) return 1'b1;
    return sb_q.size() != 0;
  endfunction

  task automatic drain(input string name);
    for (int k = 0; k < 60 && busy(); k++) tick();
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s_timeout: got outstanding work expected idle", name);
    end
  endtask

  task automatic wait_core_granted(input int i, input string name);
    for (int k = 0; k < 30 && drv_q[i].size() != 0; k++) tick();
    checks++;
    if (drv_q[i].size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got no gnt expected gnt to core %0d", name, i);
    end
  endtask

  task automatic host_write(input logic [63:0] addr, input logic [63:0] data);
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic clear_state();
    for (int i = 0; i < NumCores; i++) drv_q[i].delete();
    core_req   = '0;
    sb_q.delete();
    gl_q.delete();
    exp_grants = 0;
    exp_oob    = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_state();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_counters(input string name);
    check64({name, "_grant_count"}, grant_count, 64'(exp_grants));
    check64({name, "_oob_count"}, {32'd0, oob_count}, 64'(exp_oob));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int tbl_oob;
    vecs[0] = '{64'h100,  1'b1, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0};
    vecs[1] = '{64'h7FF8, 1'b1, 64'hCAFE_F00D_0000_0001, 64'hCAFE_F00D_0000_0001, 0};
    vecs[2] = '{64'h18,   1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[3] = '{64'h8000, 1'b1, 64'h5555, Oob, 1};
    vecs[4] = '{64'h104,  1'b1, 64'h6666, Oob, 1};
    vecs[5] = '{64'h8000_0000_0000_0100, 1'b1, 64'h7777, Oob, 1};
    vecs[6] = '{64'h100,  1'b0, 64'h0, 64'h1111_2222_3333_4444, 0};

    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    do_reset();
    check64("rst_gnt", {60'd0, core_gnt}, 64'd0);
    check64("rst_valid", {60'd0, core_valid}, 64'd0);
    check64("rst_rdata", core_rdata, 64'd0);
    check_counters("rst");

    // Preload and single read: gnt one cycle after request, data RdLat later.
    host_write(64'h0, 64'h10);
    host_write(64'h8, 64'h20);
    gl_q.delete();
    t0 = cyc;
    enq(0, 1'b0, 64'h8, 64'h0, 64'h20);
    tick();
    check_int("t1_gnt_cycle", (gl_q.size() == 1) ? gl_q[0].cyc : -1, t0 + 1);
    drain("t1");
    check_counters("t1");

    tbl_oob = 0;
    for (int k = 0; k < 7; k++) begin
      if (vecs[k].pre) host_write(vecs[k].addr, vecs[k].data);
      enq(k % NumCores, 1'b0, vecs[k].addr, 64'h0, vecs[k].exp);
      drain($sformatf("vec%0d", k));
      tbl_oob += vecs[k].oob_inc;
      check64($sformatf("vec%0d_oob", k), {32'd0, oob_count}, 64'(tbl_oob));
    end
    check_counters("vec");

    // All four cores at once from rr_ptr=0: grants 0..3 on consecutive cycles.
    do_reset();
    t0 = cyc;
    enq(0, 1'b0, 64'h0,   64'h0, 64'h10);
    enq(1, 1'b0, 64'h8,   64'h0, 64'h20);
    enq(2, 1'b0, 64'h100, 64'h0, 64'h1111_2222_3333_4444);
    enq(3, 1'b0, 64'h18,  64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("t2");
    check_int("t2_ngrants", gl_q.size(), 4);
    for (int k = 0; k < 4 && k < gl_q.size(); k++) begin
      check_int($sformatf("t2_id%0d", k), gl_q[k].id, k);
      check_int($sformatf("t2_cyc%0d", k), gl_q[k].cyc, t0 + 1 + k);
    end
    check_counters("t2");

    // One core alone holding req: granted every second cycle.
    gl_q.delete();
    for (int k = 0; k < 3; k++) enq(0, 1'b0, 64'h0, 64'h0, 64'h10);
    drain("b2b");
    check_int("b2b_ngrants", gl_q.size(), 3);
    if (gl_q.size() == 3) begin
      check_int("b2b_gap0", gl_q[1].cyc - gl_q[0].cyc, 2);
      check_int("b2b_gap1", gl_q[2].cyc - gl_q[1].cyc, 2);
    end

    // Core write then read-back by another core; misaligned read returns OOB data.
    enq(1, 1'b1, 64'h40, 64'hABCD, 64'h0);
    enq(3, 1'b0, 64'h7, 64'h0, Oob);
    wait_core_granted(1, "t3_wr");
    enq(2, 1'b0, 64'h40, 64'h0, 64'hABCD);
    drain("t3");
    check64("t3_oob_count", {32'd0, oob_count}, 64'd1);
    check_counters("t3");

    // Host write held three cycles blocks core0 until the cycle after it drops.
    gl_q.delete();
    host_we = 1'b1; host_addr = 64'h200; host_wdata = 64'hA0A0;
    t0 = cyc;
    enq(0, 1'b0, 64'h208, 64'h0, 64'hB0B0);
    tick();
    host_addr = 64'h208; host_wdata = 64'hB0B0;
    tick();
    host_addr = 64'h210; host_wdata = 64'hC0C0;
    tick();
    host_we = 1'b0;
    tick();
    check_int("t4_gnt_cycle", (gl_q.size() >= 1) ? gl_q[0].cyc : -1, t0 + 4);
    enq(1, 1'b0, 64'h210, 64'h0, 64'hC0C0);
    enq(2, 1'b0, 64'h200, 64'h0, 64'hA0A0);
    drain("t4");
    check_counters("t4");

    // Reset one cycle after a read grant: the read never returns.
    enq(0, 1'b0, 64'h8, 64'h0, 64'h20);
    wait_core_granted(0, "t5_gnt");
    tick();
    rst = 1'b1;
    clear_state();
    tick();
    check64("t5_gnt", {60'd0, core_gnt}, 64'd0);
    check64("t5_valid", {60'd0, core_valid}, 64'd0);
    check64("t5_rdata", core_rdata, 64'd0);
    check_counters("t5_rst");
    tick();
    rst = 1'b0;
    repeat (6) tick();
    enq(3, 1'b0, 64'h8, 64'h0, 64'h20);
    enq(2, 1'b0, 64'h8, 64'h0, 64'h20);
    enq(1, 1'b0, 64'h8, 64'h0, 64'h20);
    enq(0, 1'b0, 64'h8, 64'h0, 64'h20);
    drain("t5");
    check_int("t5_rr_first", (gl_q.size() > 0) ? gl_q[0].id : -1, 0);

    // Write just past the array: granted, dropped, counted; word 0 unchanged.
    enq(0, 1'b1, 64'(Depth) * 64'd8, 64'h9999, 64'h0);
    drain("t6_wr");
    enq(0, 1'b0, 64'h0, 64'h0, 64'h10);
    drain("t6_rd");
    check64("t6_oob_count", {32'd0, oob_count}, 64'd1);
    check_counters("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
